// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester arbiter and sequencer for a single-port synchronous SRAM
// Build option: SRAM_ARB_FIXED_PRI_EN selects fixed priority (requester 0 wins ties) instead of round-robin.
module sram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_rwb,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_rwb,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic                  sram_rwb,
   output logic [DATA_WIDTH-1:0] sram_data_o,
   output logic                  sram_data_oe,
   input  logic [DATA_WIDTH-1:0] sram_data_i,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   state_t                state, state_nxt;
   logic                  cur_id;
   logic                  cur_rwb;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic                  grant_valid;
   logic                  grant_id;
   logic                  accept;

`ifdef SRAM_ARB_FIXED_PRI_EN
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      grant_id    = ~req0_valid;
   end
`else
   logic last_grant;

   // On a tie the requester that was not served last time wins.
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid)
         grant_id = ~last_grant;
      else
         grant_id = req1_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= grant_id;
   end
`endif

   assign accept = (state == IDLE) && grant_valid;

   always_comb begin
      state_nxt    = state;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      sram_addr    = '0;
      sram_rwb     = 1'b0;
      sram_data_oe = 1'b0;
      sram_data_o  = '0;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_nxt  = ACCESS;
            end
         end
         ACCESS: begin
            sram_addr    = cur_addr;
            sram_rwb     = cur_rwb;
            sram_data_oe = cur_rwb;
            sram_data_o  = cur_rwb ? cur_wdata : '0;
            state_nxt    = cur_rwb ? RESP : CAPTURE;
         end
         CAPTURE: begin
            sram_addr = cur_addr;
            state_nxt = RESP;
         end
         RESP: begin
            rsp0_valid = ~cur_id;
            rsp1_valid = cur_id;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cur_id     <= 1'b0;
         cur_rwb    <= 1'b0;
         cur_addr   <= '0;
         cur_wdata  <= '0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cur_id    <= grant_id;
            cur_rwb   <= grant_id ? req1_rwb   : req0_rwb;
            cur_addr  <= grant_id ? req1_addr  : req0_addr;
            cur_wdata <= grant_id ? req1_wdata : req0_wdata;
         end
         // Read data is presented by the SRAM during CAPTURE, one edge after the access.
         if (state == CAPTURE) begin
            if (cur_id)
               rsp1_rdata <= sram_data_i;
            else
               rsp0_rdata <= sram_data_i;
         end
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with an SRAM device model and transaction-level reference
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_rwb;
   logic [7:0]  req0_addr;
   logic [31:0] req0_wdata;
   logic        rsp0_valid;
   logic [31:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_rwb;
   logic [7:0]  req1_addr;
   logic [31:0] req1_wdata;
   logic        rsp1_valid;
   logic [31:0] rsp1_rdata;
   logic [7:0]  sram_addr;
   logic        sram_rwb;
   logic [31:0] sram_data_o;
   logic        sram_data_oe;
   logic [31:0] sram_data_i;
   logic        busy;

   sram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rwb(req0_rwb),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rwb(req1_rwb),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .sram_addr(sram_addr), .sram_rwb(sram_rwb), .sram_data_o(sram_data_o),
      .sram_data_oe(sram_data_oe), .sram_data_i(sram_data_i), .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous single-port SRAM device: one access per edge.
   logic [31:0] sram_mem [0:255];
   logic [31:0] sram_q;
   always @(posedge clk) begin
      if (sram_rwb && sram_data_oe)
         sram_mem[sram_addr] <= sram_data_o;
      else
         sram_q <= sram_mem[sram_addr];
   end
   assign sram_data_i = sram_q;

   // Reference: memory contents, last response data per requester, last grant.
   logic [31:0] m_mem [0:255];
   logic [31:0] m_rd  [2];
   int          m_last;

   // Pending requests held by each requester until accepted.
   bit          pv    [2];
   logic        prwb  [2];
   logic [7:0]  paddr [2];
   logic [31:0] pwd   [2];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int exp_winner();
      if (pv[0] && !pv[1]) return 0;
      if (pv[1] && !pv[0]) return 1;
`ifdef SRAM_ARB_FIXED_PRI_EN
      return 0;
`else
      return (m_last == 0) ? 1 : 0;
`endif
   endfunction

   task automatic drive();
      req0_valid = pv[0]; req0_rwb = prwb[0]; req0_addr = paddr[0]; req0_wdata = pwd[0];
      req1_valid = pv[1]; req1_rwb = prwb[1]; req1_addr = paddr[1]; req1_wdata = pwd[1];
   endtask

   task automatic set_req(input int id, input logic rwb, input logic [7:0] addr, input logic [31:0] wd);
      pv[id] = 1'b1; prwb[id] = rwb; paddr[id] = addr; pwd[id] = wd;
   endtask

   // One IDLE cycle plus, if anything is pending, the complete transaction of the winner.
   task automatic arb_round(input string tag);
      int          win, lat;
      logic        w_rwb;
      logic [7:0]  w_addr;
      logic [31:0] w_wd;
      @(negedge clk);
      drive();
      #1;
      if (!pv[0] && !pv[1]) begin
         chk({tag, " idle ready0"}, req0_ready, 0);
         chk({tag, " idle ready1"}, req1_ready, 0);
         return;
      end
      win = exp_winner();
      chk({tag, " ready0"}, req0_ready, (win == 0));
      chk({tag, " ready1"}, req1_ready, (win == 1));
      w_rwb = prwb[win]; w_addr = paddr[win]; w_wd = pwd[win];
      lat = w_rwb ? 2 : 3;
      @(posedge clk);
      m_last = win;
      if (w_rwb) m_mem[w_addr] = w_wd;
      else       m_rd[win] = m_mem[w_addr];
      pv[win] = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         drive();
         #1;
         chk({tag, " busy"}, busy, 1);
         chk({tag, " ready0 busy"}, req0_ready, 0);
         chk({tag, " ready1 busy"}, req1_ready, 0);
         chk({tag, " sram_oe"}, sram_data_oe, (c == 1 && w_rwb));
         chk({tag, " sram_rwb"}, sram_rwb, (c == 1 && w_rwb));
         if (c == 1 || (c == 2 && !w_rwb)) chk({tag, " sram_addr"}, sram_addr, w_addr);
         if (c == 1 && w_rwb) chk({tag, " sram_data_o"}, sram_data_o, w_wd);
         chk({tag, " rsp0_valid"}, rsp0_valid, (c == lat && win == 0));
         chk({tag, " rsp1_valid"}, rsp1_valid, (c == lat && win == 1));
         if (c == lat) begin
            chk({tag, " rsp0_rdata"}, rsp0_rdata, m_rd[0]);
            chk({tag, " rsp1_rdata"}, rsp1_rdata, m_rd[1]);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 256; a++) begin
         sram_mem[a] = '0;
         m_mem[a]    = '0;
      end
      m_rd[0] = '0; m_rd[1] = '0; m_last = 1;
      for (int i = 0; i < 2; i++) begin
         pv[i] = 1'b0; prwb[i] = 1'b0; paddr[i] = '0; pwd[i] = '0;
      end
      drive();

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst busy", busy, 0);
      chk("rst sram_rwb", sram_rwb, 0);
      chk("rst sram_oe", sram_data_oe, 0);
      chk("rst sram_addr", sram_addr, 0);
      chk("rst rsp0_valid", rsp0_valid, 0);
      chk("rst rsp1_valid", rsp1_valid, 0);
      chk("rst rsp0_rdata", rsp0_rdata, 0);
      chk("rst rsp1_rdata", rsp1_rdata, 0);
      rst = 1'b0;

      // req0 write then read-back of the same address
      set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
      arb_round("wr0");
      set_req(0, 1'b0, 8'h10, 32'h0);
      arb_round("rd0");

      // Reset during CAPTURE of a req1 read
      @(negedge clk);
      req1_valid = 1'b1; req1_rwb = 1'b0; req1_addr = 8'h20; req1_wdata = '0;
      @(posedge clk);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("capture busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst busy", busy, 0);
      chk("midrst sram_rwb", sram_rwb, 0);
      chk("midrst sram_oe", sram_data_oe, 0);
      chk("midrst sram_addr", sram_addr, 0);
      chk("midrst rsp1_valid", rsp1_valid, 0);
      chk("midrst rsp0_rdata", rsp0_rdata, 0);
      chk("midrst rsp1_rdata", rsp1_rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      m_rd[0] = '0; m_rd[1] = '0; m_last = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("postrst rsp1_valid", rsp1_valid, 0);
         chk("postrst busy", busy, 0);
      end

      // Both requesters continuously valid
      for (int k = 0; k < 6; k++) begin
         if (!pv[0]) set_req(0, 1'b1, 8'h01, $urandom);
         if (!pv[1]) set_req(1, 1'b1, 8'h02, $urandom);
         arb_round("tie");
      end
      // Let any request left pending by the tie phase drain
      arb_round("drain");
      arb_round("drain");

      // Post-reset req1 read, then cross-requester write/read
      set_req(1, 1'b0, 8'h20, 32'h0);
      arb_round("rd1");
      set_req(1, 1'b1, 8'h20, 32'h12345678);
      arb_round("wr1");
      set_req(0, 1'b0, 8'h20, 32'h0);
      arb_round("rd0x20");

      // Randomised mix on a small address window
      for (int k = 0; k < 60; k++) begin
         for (int i = 0; i < 2; i++)
            if (!pv[i] && $urandom_range(0, 2) != 0)
               set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
         arb_round("rand");
      end
      arb_round("final");
      arb_round("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
